// File: rtl/hazard_fwd_ctrl_if.sv
// ID-stage operands, producer-stage destinations and pipeline events in;
// forwarding selects, stall controls and the stall-cycle count out.
interface hazard_fwd_ctrl_if #(
  parameter int NUM_SRC    = 2,
  parameter int FWD_STAGES = 3,
  parameter int REG_ADDR_W = 5,
  parameter int SEL_W      = $clog2(FWD_STAGES + 1)
);
  logic                             id_valid;
  logic [NUM_SRC-1:0]               id_src_used;
  logic [NUM_SRC*REG_ADDR_W-1:0]    id_rs;
  logic [FWD_STAGES*REG_ADDR_W-1:0] stage_rd;
  logic [FWD_STAGES-1:0]            stage_rf_e;
  logic                             ex_load;
  logic                             mdu_start;
  logic                             mdu_done;
  logic                             flush;
  logic [NUM_SRC*SEL_W-1:0]         fwd_sel;
  logic                             pc_en;
  logic                             if_id_en;
  logic                             id_ex_bubble;
  logic                             ex_hold;
  logic [31:0]                      stall_cycles;

  modport master (
    output id_valid, id_src_used, id_rs, stage_rd, stage_rf_e,
           ex_load, mdu_start, mdu_done, flush,
    input  fwd_sel, pc_en, if_id_en, id_ex_bubble, ex_hold, stall_cycles
  );

  modport slave (
    input  id_valid, id_src_used, id_rs, stage_rd, stage_rf_e,
           ex_load, mdu_start, mdu_done, flush,
    output fwd_sel, pc_en, if_id_en, id_ex_bubble, ex_hold, stall_cycles
  );
endinterface

// File: rtl/hazard_fwd_ctrl.sv
// Operand forwarding selects plus load-use / MDU / flush stall control; all outputs are
// combinational from registered state and current inputs, so the first stall cycle is the detection cycle.
module hazard_fwd_ctrl #(
  parameter int NUM_SRC    = 2,
  parameter int FWD_STAGES = 3,
  parameter int REG_ADDR_W = 5,
  parameter int LOAD_LAT   = 1,
  parameter int SEL_W      = $clog2(FWD_STAGES + 1)
) (
  input logic              clk,
  input logic              reset,
  hazard_fwd_ctrl_if.slave bus
);
  localparam int CNT_W = 3;
  localparam logic [CNT_W-1:0] LOAD_CNT_INIT = CNT_W'((LOAD_LAT > 1) ? LOAD_LAT - 2 : 0);

  typedef enum logic [1:0] {RUN, LOAD_STALL, MDU_WAIT} state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [31:0]              stall_cnt;
  logic [NUM_SRC*SEL_W-1:0] fwd_sel_c;
  logic                     src_hit_ex;
  logic                     load_haz;
  logic                     load_stall;
  logic                     mdu_stall;
  logic                     stall;

  // Stages are scanned farthest-first so the nearest matching producer wins.
  always_comb begin : fwd_decode
    logic [REG_ADDR_W-1:0] rs;
    logic [SEL_W-1:0]      sel;
    fwd_sel_c  = '0;
    src_hit_ex = 1'b0;
    rs         = '0;
    sel        = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      rs  = bus.id_rs[i*REG_ADDR_W +: REG_ADDR_W];
      sel = '0;
      if (bus.id_src_used[i] && (rs != '0)) begin
        for (int k = FWD_STAGES - 1; k >= 0; k--) begin
          if (bus.stage_rf_e[k] && (bus.stage_rd[k*REG_ADDR_W +: REG_ADDR_W] == rs))
            sel = SEL_W'(k + 1);
        end
        if (bus.stage_rd[REG_ADDR_W-1:0] == rs)
          src_hit_ex = 1'b1;
      end
      fwd_sel_c[i*SEL_W +: SEL_W] = sel;
    end
  end

  assign load_haz = bus.id_valid && bus.ex_load && bus.stage_rf_e[0] &&
                    (bus.stage_rd[REG_ADDR_W-1:0] != '0) && src_hit_ex;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    load_stall = 1'b0;
    mdu_stall  = 1'b0;
    if (reset || bus.flush) begin
      state_d = RUN;
      cnt_d   = '0;
    end else begin
      case (state_q)
        RUN: begin
          if (bus.mdu_start) begin
            mdu_stall = 1'b1;
            state_d   = MDU_WAIT;
          end else if (load_haz) begin
            load_stall = 1'b1;
            if (LOAD_LAT > 1) begin
              state_d = LOAD_STALL;
              cnt_d   = LOAD_CNT_INIT;
            end
          end
        end
        LOAD_STALL: begin
          load_stall = 1'b1;
          if (cnt_q == '0) state_d = RUN;
          else             cnt_d   = cnt_q - 1'b1;
        end
        MDU_WAIT: begin
          if (bus.mdu_done) state_d   = RUN;
          else              mdu_stall = 1'b1;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stall = load_stall | mdu_stall;

  always_ff @(posedge clk) begin
    if (reset)
      stall_cnt <= '0;
    else if (stall && (stall_cnt != '1))
      stall_cnt <= stall_cnt + 32'd1;
  end

  assign bus.fwd_sel      = reset ? '0 : fwd_sel_c;
  assign bus.pc_en        = ~stall;
  assign bus.if_id_en     = ~stall;
  assign bus.id_ex_bubble = load_stall;
  assign bus.ex_hold      = mdu_stall;
  assign bus.stall_cycles = stall_cnt;
endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Three controllers (LOAD_LAT 1, 3, 4) share one stimulus stream; a behavioural model
// queues expected outputs per cycle and they are popped against the DUTs before the edge.
module tb_hazard_fwd_ctrl;
  localparam int NS = 2;
  localparam int FS = 3;
  localparam int RW = 5;
  localparam int SW = $clog2(FS + 1);
  localparam int NI = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic                   id_valid;
  logic [NS-1:0]          used;
  logic [NS-1:0][RW-1:0]  rs;
  logic [FS-1:0][RW-1:0]  rd;
  logic [FS-1:0]          rfe;
  logic                   ex_load, mdu_start, mdu_done, flush;

  logic [NI-1:0]                o_pc, o_ifid, o_bub, o_hold;
  logic [NI-1:0][NS*SW-1:0]     o_fwd;
  logic [NI-1:0][31:0]          o_cnt;

  hazard_fwd_ctrl_if #(.NUM_SRC(NS), .FWD_STAGES(FS), .REG_ADDR_W(RW)) bus [NI] ();

  for (genvar g = 0; g < NI; g++) begin : gen_dut
    assign bus[g].id_valid    = id_valid;
    assign bus[g].id_src_used = used;
    assign bus[g].id_rs       = rs;
    assign bus[g].stage_rd    = rd;
    assign bus[g].stage_rf_e  = rfe;
    assign bus[g].ex_load     = ex_load;
    assign bus[g].mdu_start   = mdu_start;
    assign bus[g].mdu_done    = mdu_done;
    assign bus[g].flush       = flush;
    assign o_fwd[g]  = bus[g].fwd_sel;
    assign o_pc[g]   = bus[g].pc_en;
    assign o_ifid[g] = bus[g].if_id_en;
    assign o_bub[g]  = bus[g].id_ex_bubble;
    assign o_hold[g] = bus[g].ex_hold;
    assign o_cnt[g]  = bus[g].stall_cycles;

    hazard_fwd_ctrl #(
      .NUM_SRC(NS), .FWD_STAGES(FS), .REG_ADDR_W(RW),
      .LOAD_LAT(g == 0 ? 1 : (g == 1 ? 3 : 4))
    ) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus[g])
    );
  end

  typedef struct packed {
    logic [NS*SW-1:0] fwd;
    logic             pc;
    logic             ifid;
    logic             bub;
    logic             hold;
    logic [31:0]      cnt;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  // model state: mode 0 = running, 1 = load stall pending, 2 = waiting on MDU
  int          m_mode [NI], n_mode [NI];
  int          m_rem  [NI], n_rem  [NI];
  logic [31:0] m_cnt  [NI], n_cnt  [NI];
  int          obs_stall [NI], obs_bub [NI], obs_hold [NI];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  function automatic int lat_of(input int j);
    return (j == 0) ? 1 : ((j == 1) ? 3 : 4);
  endfunction

  function automatic logic [SW-1:0] mfwd(input logic [RW-1:0] a, input logic u);
    logic [SW-1:0] r;
    r = '0;
    if (u && a != '0) begin
      for (int k = 0; k < FS; k++) begin
        if (rfe[k] && rd[k] == a) begin
          r = SW'(k + 1);
          break;
        end
      end
    end
    return r;
  endfunction

  task automatic idle();
    id_valid = 1'b0; used = '0; rs = '0; rd = '0; rfe = '0;
    ex_load = 1'b0; mdu_start = 1'b0; mdu_done = 1'b0; flush = 1'b0;
  endtask

  task automatic load_use(input logic [NS-1:0] u, input logic [RW-1:0] a0,
                          input logic [RW-1:0] a1, input logic [RW-1:0] d0);
    id_valid = 1'b1; used = u; rs[0] = a0; rs[1] = a1; rd[0] = d0;
    rfe = 3'b001; ex_load = 1'b1;
  endtask

  task automatic clr_obs();
    for (int j = 0; j < NI; j++) begin
      obs_stall[j] = 0; obs_bub[j] = 0; obs_hold[j] = 0;
    end
  endtask

  // Called just after a falling edge with inputs already applied.
  task automatic step();
    exp_t e;
    logic lh, ls, ms;
    lh = id_valid && ex_load && rfe[0] && (rd[0] != '0) &&
         ((used[0] && rs[0] == rd[0]) || (used[1] && rs[1] == rd[0]));
    for (int j = 0; j < NI; j++) begin
      ls = 1'b0; ms = 1'b0;
      n_mode[j] = m_mode[j];
      n_rem[j]  = m_rem[j];
      if (reset || flush) begin
        n_mode[j] = 0;
        n_rem[j]  = 0;
      end else begin
        case (m_mode[j])
          0: begin
            if (mdu_start) begin
              ms = 1'b1; n_mode[j] = 2;
            end else if (lh) begin
              ls = 1'b1;
              n_rem[j]  = lat_of(j) - 1;
              n_mode[j] = (n_rem[j] > 0) ? 1 : 0;
            end
          end
          1: begin
            ls = 1'b1;
            n_rem[j] = m_rem[j] - 1;
            if (n_rem[j] == 0) n_mode[j] = 0;
          end
          default: begin
            if (mdu_done) n_mode[j] = 0;
            else          ms = 1'b1;
          end
        endcase
      end
      e.fwd  = reset ? '0 : {mfwd(rs[1], used[1]), mfwd(rs[0], used[0])};
      e.pc   = !(ls || ms);
      e.ifid = !(ls || ms);
      e.bub  = ls;
      e.hold = ms;
      e.cnt  = m_cnt[j];
      if (reset)                                  n_cnt[j] = '0;
      else if ((ls || ms) && m_cnt[j] != 32'hFFFF_FFFF) n_cnt[j] = m_cnt[j] + 32'd1;
      else                                        n_cnt[j] = m_cnt[j];
      sb.push_back(e);
    end
    #2;
    for (int j = 0; j < NI; j++) begin
      e = sb.pop_front();
      chk($sformatf("fwd_sel[%0d]", j),      64'(o_fwd[j]),  64'(e.fwd));
      chk($sformatf("pc_en[%0d]", j),        64'(o_pc[j]),   64'(e.pc));
      chk($sformatf("if_id_en[%0d]", j),     64'(o_ifid[j]), 64'(e.ifid));
      chk($sformatf("id_ex_bubble[%0d]", j), 64'(o_bub[j]),  64'(e.bub));
      chk($sformatf("ex_hold[%0d]", j),      64'(o_hold[j]), 64'(e.hold));
      chk($sformatf("stall_cycles[%0d]", j), 64'(o_cnt[j]),  64'(e.cnt));
      obs_stall[j] += (o_pc[j] == 1'b0) ? 1 : 0;
      obs_bub[j]   += (o_bub[j] == 1'b1) ? 1 : 0;
      obs_hold[j]  += (o_hold[j] == 1'b1) ? 1 : 0;
    end
    @(posedge clk);
    for (int j = 0; j < NI; j++) begin
      m_mode[j] = n_mode[j];
      m_rem[j]  = n_rem[j];
      m_cnt[j]  = n_cnt[j];
    end
    @(negedge clk);
  endtask

  initial begin
    idle();
    reset = 1'b1;
    for (int j = 0; j < NI; j++) begin
      m_mode[j] = 0; m_rem[j] = 0; m_cnt[j] = '0;
    end
    clr_obs();
    repeat (2) @(posedge clk);
    @(negedge clk);

    // reset masks forwarding and stalls even with a live load-use hazard
    load_use(2'b01, 5'd7, 5'd0, 5'd7);
    step();
    reset = 1'b0;
    idle();
    step();

    // load-use on rs1
    clr_obs();
    load_use(2'b01, 5'd5, 5'd0, 5'd5);
    step();
    idle();
    repeat (5) step();
    chk("ld_rs1_stalls_L1", 64'(obs_stall[0]), 64'd1);
    chk("ld_rs1_stalls_L3", 64'(obs_stall[1]), 64'd3);
    chk("ld_rs1_stalls_L4", 64'(obs_stall[2]), 64'd4);
    chk("ld_rs1_bubbles_L4", 64'(obs_bub[2]), 64'd4);
    chk("ld_rs1_count_L1", 64'(o_cnt[0]), 64'd1);

    // load-use on rs2, both sources used
    clr_obs();
    load_use(2'b11, 5'd3, 5'd9, 5'd9);
    step();
    idle();
    repeat (5) step();
    chk("ld_rs2_stalls_L3", 64'(obs_stall[1]), 64'd3);
    chk("ld_rs2_stalls_L1", 64'(obs_stall[0]), 64'd1);

    // same addresses, rs2 unused -> no hazard
    clr_obs();
    load_use(2'b01, 5'd3, 5'd9, 5'd9);
    step();
    idle();
    repeat (3) step();
    chk("ld_unused_stalls", 64'(obs_stall[0] + obs_stall[1] + obs_stall[2]), 64'd0);

    // forwarding priority
    id_valid = 1'b1; used = 2'b11; rs[0] = 5'd7; rd[0] = 5'd7; rd[2] = 5'd7; rfe = 3'b101;
    step();
    chk("fwd_nearest", 64'(o_fwd[0][SW-1:0]), 64'd1);
    rfe = 3'b100;
    step();
    chk("fwd_wb", 64'(o_fwd[0][SW-1:0]), 64'd3);
    rs[0] = 5'd0;
    step();
    chk("fwd_x0", 64'(o_fwd[0][SW-1:0]), 64'd0);
    rs[1] = 5'd4; rd[1] = 5'd4; rfe = 3'b010;
    step();
    chk("fwd_rs2_mem", 64'(o_fwd[1][2*SW-1:SW]), 64'd2);
    used = 2'b00;
    step();
    rd[0] = 5'd0; rs[0] = 5'd0; used = 2'b11; rfe = 3'b111; ex_load = 1'b1;
    step();

    // MDU: start at t0, done at t4
    idle();
    clr_obs();
    mdu_start = 1'b1;
    step();
    mdu_start = 1'b0;
    repeat (3) step();
    mdu_done = 1'b1;
    step();
    mdu_done = 1'b0;
    repeat (2) step();
    chk("mdu_hold_L1", 64'(obs_hold[0]), 64'd4);
    chk("mdu_stalls_L4", 64'(obs_stall[2]), 64'd4);

    // stray mdu_done in RUN
    clr_obs();
    mdu_done = 1'b1;
    step();
    mdu_done = 1'b0;
    step();
    chk("mdu_done_idle", 64'(obs_stall[0] + obs_stall[1] + obs_stall[2]), 64'd0);

    // MDU start and load hazard together, done one cycle later
    clr_obs();
    load_use(2'b01, 5'd6, 5'd0, 5'd6);
    mdu_start = 1'b1;
    step();
    idle();
    mdu_done = 1'b1;
    step();
    mdu_done = 1'b0;
    repeat (4) step();
    chk("mdu_vs_ld_stalls_L4", 64'(obs_stall[2]), 64'd1);
    chk("mdu_vs_ld_bubbles_L4", 64'(obs_bub[2]), 64'd0);

    // flush in the second load-stall cycle
    clr_obs();
    load_use(2'b01, 5'd8, 5'd0, 5'd8);
    step();
    idle();
    flush = 1'b1;
    step();
    flush = 1'b0;
    repeat (4) step();
    chk("flush_ld_stalls_L4", 64'(obs_stall[2]), 64'd1);
    chk("flush_ld_stalls_L3", 64'(obs_stall[1]), 64'd1);

    // flush beats mdu_start
    clr_obs();
    mdu_start = 1'b1; flush = 1'b1;
    step();
    idle();
    repeat (2) step();
    chk("flush_mdu_hold", 64'(obs_hold[0]), 64'd0);

    // reset while waiting on the MDU
    mdu_start = 1'b1;
    step();
    mdu_start = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_mdu_hold", 64'(o_hold[1]), 64'd0);
    chk("rst_mdu_count", 64'(o_cnt[1]), 64'd0);
    step();

    // counter saturation
    force gen_dut[0].u_dut.stall_cnt = 32'hFFFF_FFFF;
    #1;
    release gen_dut[0].u_dut.stall_cnt;
    m_cnt[0] = 32'hFFFF_FFFF;
    load_use(2'b01, 5'd2, 5'd0, 5'd2);
    step();
    idle();
    mdu_start = 1'b1;
    step();
    mdu_start = 1'b0;
    mdu_done = 1'b1;
    step();
    mdu_done = 1'b0;
    chk("cnt_saturated", 64'(o_cnt[0]), 64'hFFFF_FFFF);

    // random traffic with small register space to provoke matches
    for (int n = 0; n < 300; n++) begin
      reset     = ($urandom_range(0, 63) == 0);
      id_valid  = 1'($urandom_range(0, 1));
      used      = NS'($urandom_range(0, 3));
      for (int i = 0; i < NS; i++) rs[i] = RW'($urandom_range(0, 3));
      for (int k = 0; k < FS; k++) rd[k] = RW'($urandom_range(0, 3));
      rfe       = FS'($urandom_range(0, 7));
      ex_load   = 1'($urandom_range(0, 1));
      mdu_start = ($urandom_range(0, 7) == 0);
      mdu_done  = ($urandom_range(0, 3) == 0);
      flush     = ($urandom_range(0, 15) == 0);
      step();
    end
    reset = 1'b0;
    idle();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/hazard_fwd_ctrl.md
# hazard_fwd_ctrl

Parametrised hazard-detection and operand-forwarding controller for the pipelined RISC-V core. It sits beside the ID stage and generates one forwarding-mux select per source operand across a configurable number of downstream producer stages. It owns a registered stall state machine covering multi-cycle load-use latency, multi-cycle MDU operations held in EX, and branch-flush recovery. It also keeps a saturating stall-cycle performance counter.

## Interface
Parameters:
- NUM_SRC, 2: source operands per instruction (2 or 3).
- FWD_STAGES, 3: producer stages checked; index 0 = EX (nearest), then MEM, WB, and so on (1..4).
- REG_ADDR_W, 5: register address width.
- LOAD_LAT, 1: cycles a dependent instruction must stall behind a load in EX (1..7).
- SEL_W, derived: clog2(FWD_STAGES+1).

Ports (clock and reset: one clock, reset synchronous active-high):
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- id_valid  in  1  ID holds a valid instruction.
- id_src_used  in  NUM_SRC  bit i set when source i is read by the ID instruction.
- id_rs  in  NUM_SRC*REG_ADDR_W  packed source addresses; source i is at [i*REG_ADDR_W +: REG_ADDR_W].
- stage_rd  in  FWD_STAGES*REG_ADDR_W  packed destination address per producer stage.
- stage_rf_e  in  FWD_STAGES  register-file write enable per producer stage.
- ex_load  in  1  instruction in EX is a load.
- mdu_start  in  1  multi-cycle MDU op entered EX this cycle.
- mdu_done  in  1  MDU result valid this cycle.
- flush  in  1  taken branch or jump; kill IF/ID.
- fwd_sel  out  NUM_SRC*SEL_W  per source: 0 = register file; k+1 = forward from stage k.
- pc_en  out  1  PC write enable.
- if_id_en  out  1  IF/ID register enable.
- id_ex_bubble  out  1  force a NOP into ID/EX.
- ex_hold  out  1  freeze ID/EX and EX (MDU busy).
- stall_cycles  out  32  saturating count of cycles with pc_en = 0.

## Operation
- Forwarding (combinational): for source i with id_src_used[i] = 1 and rs != 0:
  - Select the lowest k with stage_rf_e[k] = 1 and stage_rd[k] == rs, giving fwd_sel = k+1.
  - If there is no match, or the source is unused, or rs == 0, fwd_sel = 0.
  - A destination of x0 never forwards.
- load_haz = id_valid & ex_load & stage_rf_e[0] & stage_rd[0] != 0, AND some used source matches stage_rd[0].
- FSM states:
  - RUN:
    - flush: stay in RUN.
    - Else mdu_start: go to MDU_WAIT (stall this cycle).
    - Else load_haz: stall this cycle. If LOAD_LAT > 1, go to LOAD_STALL with cnt = LOAD_LAT-2; else stay in RUN.
  - LOAD_STALL:
    - Stall each cycle.
    - If cnt == 0, go to RUN; else decrement cnt.
    - Hazards are not re-evaluated while in this state.
  - MDU_WAIT:
    - Stall each cycle mdu_done = 0.
    - On mdu_done = 1 the stall is released in that same cycle, and the FSM goes to RUN.
- Priority: flush > MDU > load.
  - flush in any state forces RUN next cycle.
  - flush clears cnt.
  - flush deasserts every stall output combinationally in the flush cycle. IF/ID clearing belongs to the pipeline.
- Output decode:
  - Load stall: pc_en = 0, if_id_en = 0, id_ex_bubble = 1, ex_hold = 0.
  - MDU stall: pc_en = 0, if_id_en = 0, id_ex_bubble = 0, ex_hold = 1.
  - Otherwise: pc_en = 1, if_id_en = 1, id_ex_bubble = 0, ex_hold = 0.
- stall_cycles increments on every cycle with pc_en = 0 and saturates at 0xFFFFFFFF.

## Timing
- Reset values: state = RUN, cnt = 0, stall_cycles = 0.
- Outputs while reset is high: pc_en = 1, if_id_en = 1, id_ex_bubble = 0, ex_hold = 0, fwd_sel = 0.
- Reset asserted mid-stall aborts the stall; outputs return to the run values in the same cycle.
- fwd_sel has zero latency from its inputs.
- Stall outputs are a combinational function of the registered state plus the current inputs. The first stall cycle coincides with hazard detection.
- A load-use hazard stalls exactly LOAD_LAT cycles.
- An MDU op stalls (N+1) cycles, where N = the number of cycles strictly between mdu_start and mdu_done. If mdu_done arrives one cycle after mdu_start, the stall is 1 cycle.
- mdu_done while in RUN is ignored.
- mdu_start and load_haz in the same cycle: MDU wins, and no load stall is queued.

## Test plan
- Load-use on rs1: rs1 = 5, stage_rd[0] = 5, ex_load = 1, LOAD_LAT = 1 -> 1 cycle with pc_en = 0 and id_ex_bubble = 1; stall_cycles = 1.
- LOAD_LAT = 3, load-use on rs2 with id_src_used = 2'b11 -> exactly 3 stall cycles, then pc_en = 1. With id_src_used = 2'b01 -> no stall.
- Forward priority: rs1 = 7 matches stages 0 and 2 with rf_e = 3'b101 -> fwd_sel[0] = 1. Clear rf_e[0] -> fwd_sel[0] = 3. rs1 = 0 -> fwd_sel[0] = 0.
- MDU: mdu_start at t0, mdu_done at t4 -> ex_hold = 1 for t0..t3 and released at t4; stall_cycles += 4.
- Flush during LOAD_STALL (LOAD_LAT = 4, flush in second stall cycle) -> pc_en = 1 that cycle; state returns to RUN.
- Reset during MDU_WAIT -> next cycle state = RUN, ex_hold = 0, stall_cycles = 0. Also force the counter to 0xFFFFFFFF, stall one cycle -> it stays saturated.
